// File: rtl/cnc_pos_pkg.sv
// rtl/cnc_pos_pkg.sv - shared position types and the saturating add used by the position accumulators
package cnc_pos_pkg;

  localparam int POS_WIDTH = 32;
  localparam int SAT_WIDTH = 64;

  typedef logic signed [POS_WIDTH-1:0] pos_t;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } track_state_t;

  typedef struct packed {
    logic signed [SAT_WIDTH-1:0] value;
    logic                        ovf;
  } sat_t;

  // Operands arrive sign-extended to SAT_WIDTH; the clamp is applied at a signed range of 'width' bits.
  function automatic sat_t sat_add(input logic signed [SAT_WIDTH-1:0] acc,
                                   input logic signed [SAT_WIDTH-1:0] delta,
                                   input int width);
    logic signed [SAT_WIDTH-1:0] sum;
    logic signed [SAT_WIDTH-1:0] max_v;
    logic signed [SAT_WIDTH-1:0] min_v;
    sat_t r;
    sum   = acc + delta;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    r.value = sum;
    r.ovf   = 1'b0;
    if (sum > max_v) begin
      r.value = max_v;
      r.ovf   = 1'b1;
    end else if (sum < min_v) begin
      r.value = min_v;
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wrap_delta.sv
// rtl/wrap_delta.sv - stage 1: reference tracking and modular sample-to-sample delta
module wrap_delta
  import cnc_pos_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                load,
  input  logic                valid_in,
  input  logic [IN_WIDTH-1:0] data_in,
  output logic                s1_valid,
  output logic [IN_WIDTH-1:0] delta
);

  track_state_t state, state_next;
  logic [IN_WIDTH-1:0] prev;

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = valid_in ? TRACK : EMPTY;
    end else if (valid_in) begin
      state_next = TRACK;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A sample taken with no reference, or during a load, only becomes the new reference.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      prev     <= '0;
      delta    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= valid_in & ~load;
      if (valid_in) begin
        prev <= data_in;
        if (load || state == EMPTY) begin
          delta <= '0;
        end else begin
          delta <= data_in - prev;
        end
      end
    end
  end

endmodule

// File: rtl/wrap_unwrap_acc.sv
// rtl/wrap_unwrap_acc.sv - widens a wrapping sample stream into a saturating signed position
module wrap_unwrap_acc
  import cnc_pos_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] load_value,
  input  logic                 clear_ovf,
  input  logic                 valid_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic                 valid_out,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 ovf
);

  generate
    if (OUT_WIDTH <= IN_WIDTH || OUT_WIDTH > SAT_WIDTH - 2) begin : g_bad_width
      $error("wrap_unwrap_acc: OUT_WIDTH must exceed IN_WIDTH and fit the saturating adder");
    end
  endgenerate

  logic                        s1_valid;
  logic [IN_WIDTH-1:0]         delta;
  logic signed [SAT_WIDTH-1:0] acc_ext;
  logic signed [SAT_WIDTH-1:0] delta_ext;
  sat_t                        sat;
  logic                        sat_unused;

  wrap_delta #(
    .IN_WIDTH(IN_WIDTH)
  ) u_wrap_delta (
    .clock    (clock),
    .resetn   (resetn),
    .load     (load),
    .valid_in (valid_in),
    .data_in  (data_in),
    .s1_valid (s1_valid),
    .delta    (delta)
  );

  assign acc_ext   = {{(SAT_WIDTH-OUT_WIDTH){result[OUT_WIDTH-1]}}, result};
  assign delta_ext = {{(SAT_WIDTH-IN_WIDTH){delta[IN_WIDTH-1]}}, delta};

  always_comb begin
    sat = sat_add(acc_ext, delta_ext, OUT_WIDTH);
  end

  // After clamping, the upper bits are only a sign extension of the result.
  assign sat_unused = ^sat.value[SAT_WIDTH-1:OUT_WIDTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      result    <= '0;
      valid_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        result    <= load_value;
        valid_out <= 1'b0;
      end else begin
        valid_out <= s1_valid;
        if (s1_valid) begin
          result <= sat.value[OUT_WIDTH-1:0];
        end
      end
      ovf <= (s1_valid & ~load & sat.ovf) | (ovf & ~clear_ovf);
    end
  end

endmodule

// File: tb/tb_wrap_unwrap_acc.sv
// tb/tb_wrap_unwrap_acc.sv - self-checking bench for wrap_unwrap_acc at IN_WIDTH=8, OUT_WIDTH=12
module tb_wrap_unwrap_acc;

  logic               clock;
  logic               resetn;
  logic               load;
  logic [11:0]        load_value;
  logic               clear_ovf;
  logic               valid_in;
  logic [7:0]         data_in;
  logic               valid_out;
  logic signed [11:0] result;
  logic               ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic               v;
    logic               ld;
    logic signed [11:0] lv;
    logic [7:0]         d;
    logic               out;
    logic signed [11:0] res;
    logic               ov;
  } vec_t;

  typedef struct {
    logic signed [11:0] res;
    logic               ov;
  } exp_t;

  vec_t tbl[20];
  exp_t sbq[$];

  wrap_unwrap_acc #(
    .IN_WIDTH (8),
    .OUT_WIDTH(12)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .load      (load),
    .load_value(load_value),
    .clear_ovf (clear_ovf),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .result    (result),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic v, input logic ld, input int lv, input int d,
                              input logic out, input int res, input logic ov);
    vec_t e;
    e.v   = v;
    e.ld  = ld;
    e.lv  = 12'(lv);
    e.d   = 8'(d);
    e.out = out;
    e.res = 12'(res);
    e.ov  = ov;
    return e;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic o);
    exp_t e;
    e.res = 12'(r);
    e.ov  = o;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic rn, input logic v, input logic ld, input int lv,
                       input int d, input logic clr);
    resetn     = rn;
    valid_in   = v;
    load       = ld;
    load_value = 12'(lv);
    data_in    = 8'(d);
    clear_ovf  = clr;
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid_out actual result=%0d required=no output", result);
      end else begin
        e = sbq.pop_front();
        if (result !== e.res || ovf !== e.ov) begin
          fails++;
          $display("FAIL sample_output actual result=%0d ovf=%0b required result=%0d ovf=%0b",
                   result, ovf, e.res, e.ov);
        end
      end
    end
  end

  initial begin
    int budget;
    // v, ld, load_value, data, produces output, expected result, expected ovf
    tbl[0]  = mk(1, 0, 0,     8'h10, 1, 0,     0);
    tbl[1]  = mk(1, 0, 0,     8'h20, 1, 16,    0);
    tbl[2]  = mk(0, 0, 0,     0,     0, 0,     0);
    tbl[3]  = mk(1, 1, 0,     8'hF0, 0, 0,     0);
    tbl[4]  = mk(1, 0, 0,     8'h10, 1, 32,    0);
    tbl[5]  = mk(1, 0, 0,     8'hF0, 1, 0,     0);
    tbl[6]  = mk(1, 0, 0,     8'h80, 1, -112,  0);
    tbl[7]  = mk(0, 0, 0,     0,     0, 0,     0);
    tbl[8]  = mk(1, 1, 0,     8'h00, 0, 0,     0);
    tbl[9]  = mk(1, 0, 0,     8'h80, 1, -128,  0);
    tbl[10] = mk(0, 0, 0,     0,     0, 0,     0);
    tbl[11] = mk(1, 1, 2040,  8'h00, 0, 0,     0);
    tbl[12] = mk(1, 0, 0,     8'h7F, 1, 2047,  1);
    tbl[13] = mk(1, 0, 0,     8'h70, 1, 2032,  1);
    tbl[14] = mk(0, 0, 0,     0,     0, 0,     0);
    tbl[15] = mk(1, 1, -2040, 8'h00, 0, 0,     0);
    tbl[16] = mk(1, 0, 0,     8'h80, 1, -2048, 1);
    tbl[17] = mk(1, 0, 0,     8'h00, 1, -2048, 1);
    tbl[18] = mk(1, 0, 0,     8'h7F, 1, -1921, 1);
    tbl[19] = mk(0, 0, 0,     0,     0, 0,     0);

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("reset_result", result, 0);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_ovf", ovf, 0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].v && !tbl[i].ld && tbl[i].out) push(tbl[i].res, tbl[i].ov);
      drive(1, tbl[i].v, tbl[i].ld, tbl[i].lv, tbl[i].d, 0);
    end
    chk("hold_result", result, -1921);
    chk("hold_ovf", ovf, 1);

    // clear, then collide a fresh saturation with clear_ovf on the same edge
    drive(1, 0, 0, 0, 0, 1);
    chk("clear_ovf", ovf, 0);
    drive(1, 1, 1, 2040, 8'h00, 0);
    push(2047, 1);
    drive(1, 1, 0, 0, 8'h7F, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    chk("set_wins_ovf", ovf, 1);
    drive(1, 0, 0, 0, 0, 1);
    chk("clear_after_set", ovf, 0);

    // load while a delta is in flight and a sample is offered
    drive(1, 1, 0, 0, 8'h10, 0);
    drive(1, 1, 1, -5, 8'h40, 0);
    chk("load_valid_out", valid_out, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("load_result", result, -5);
    push(-3, 0);
    drive(1, 1, 0, 0, 8'h42, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // reset in the middle of a stream
    drive(1, 1, 1, 0, 8'h00, 0);
    push(5, 0);
    drive(1, 1, 0, 0, 8'h05, 0);
    drive(1, 1, 0, 0, 8'h06, 0);
    drive(0, 1, 0, 0, 8'h07, 0);
    chk("midreset_result", result, 0);
    chk("midreset_valid_out", valid_out, 0);
    push(0, 0);
    drive(1, 1, 0, 0, 8'h30, 0);
    push(8, 0);
    drive(1, 1, 0, 0, 8'h38, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("post_reset_result", result, 8);

    budget = 0;
    while (sbq.size() != 0 && budget < 10) begin
      drive(1, 0, 0, 0, 0, 0);
      budget++;
    end
    chk("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrap_unwrap_acc.md
Name: wrap_unwrap_acc

Overview:
Widening counterpart of the saturating narrowers. It takes a stream of narrow, free-running, wrap-around samples, such as an encoder or step counter of IN_WIDTH bits. It rebuilds a wide signed position of OUT_WIDTH bits by accumulating the modular sample-to-sample delta. It sits between the encoder/step capture logic and the motion/position registers, and saturates instead of wrapping at the wide range.

Parameters:
IN_WIDTH, 16, width of the wrapping input sample (two's-complement modular).
OUT_WIDTH, 32, width of the signed accumulated result. Must be greater than IN_WIDTH; elaboration error otherwise.

Ports:
clock  in  1  system clock, all logic on posedge.
resetn  in  1  synchronous reset, active-low.
load  in  1  preset strobe.
load_value  in  OUT_WIDTH  signed preset value.
clear_ovf  in  1  clears the sticky overflow flag.
valid_in  in  1  sample strobe.
data_in  in  IN_WIDTH  wrapping sample.
valid_out  out  1  result update strobe, one pulse per accepted sample.
result  out  OUT_WIDTH  signed accumulated position.
ovf  out  1  sticky flag: saturation occurred.

Behaviour:
- Reset (resetn=0 at posedge):
  - result=0, valid_out=0, ovf=0.
  - Stage-1 valid=0, prev=0.
  - State=EMPTY.
- States:
  - EMPTY: no reference sample held.
  - TRACK: prev holds the last accepted sample.
- Stage 1, registered, on valid_in:
  - EMPTY: prev<=data_in, delta<=0, go to TRACK.
  - TRACK: delta<=signed'(data_in-prev) in IN_WIDTH bits (modular), prev<=data_in.
  - s1_valid<=valid_in.
- Delta range:
  - Range is -2^(IN_WIDTH-1) .. 2^(IN_WIDTH-1)-1.
  - A difference of exactly half the range is negative (e.g. 0x00->0x80 with IN_WIDTH=8 is -128).
- Stage 2, on s1_valid:
  - sum = result + sign-extended delta, computed in OUT_WIDTH+1 bits.
  - If sum > MAX (2^(OUT_WIDTH-1)-1): result<=MAX, ovf<=1.
  - If sum < MIN (-2^(OUT_WIDTH-1)): result<=MIN, ovf<=1.
  - Otherwise result<=sum.
  - valid_out<=1 for one cycle. valid_out=0 when s1_valid=0.
- Latency: valid_in at cycle N gives valid_out and the updated result at cycle N+2. Throughput is one sample per clock.
- Saturation is a pure clamp. No hidden excess is tracked, so an opposite delta moves result off the clamp immediately.
- ovf:
  - Sticky; cleared only by clear_ovf or reset.
  - If clear_ovf and a new saturation occur in the same cycle, set wins: ovf=1.
- load (priority over all other updates):
  - result<=load_value; s1_valid<=0, so any in-flight delta is discarded; valid_out<=0.
  - State goes to EMPTY, or to TRACK with prev<=data_in and delta 0 if valid_in is also high that cycle.
  - A sample accepted in a load cycle produces no valid_out.
- result holds its value between samples.
- Reset mid-stream discards both pipeline stages; the first sample after reset only sets the reference and produces result=0.

Decomposition:
- Package cnc_pos_pkg:
  - typedef pos_t (signed [OUT_WIDTH-1:0]).
  - Function sat_add(acc, delta) returning the clamped value and an overflow bit.
  - The sat_add function follows the same MAX/MIN rule as the shared limiters.
- One sub-module, wrap_delta: holds the stage-1 register, the EMPTY/TRACK state, prev and delta, and honours load flush.
- The top level holds stage 2 and ovf.

Test Plan (IN_WIDTH=8, OUT_WIDTH=12, MAX=2047, MIN=-2048):
1. Reset, then valid_in samples 0x10 and 0x20 on consecutive cycles -> valid_out on cycles +2 and +3 with result 0 then 16; ovf=0.
2. Forward and backward wrap:
   - Samples 0xF0 then 0x10 -> result +32.
   - Then 0xF0 -> result returns to 0.
   - Then 0x80 -> -112.
3. Half-range edge: after a reference of 0x00, sample 0x80 -> delta -128, result -128.
4. Saturation:
   - load_value=2040, then samples 0x00 and 0x7F -> result 2047, ovf=1.
   - Then sample 0x70 -> result 2032, ovf still 1.
   - Pulse clear_ovf -> ovf=0.
5. Load collision:
   - In TRACK with a delta in flight, assert load=1 (load_value=-5) with valid_in=1 and data_in=0x40 -> no valid_out for that sample or the flushed delta; result=-5.
   - Next sample 0x42 -> result -3.
6. Mid-stream reset: resetn low for one cycle while valid_in is streaming -> result=0, valid_out=0 next cycle; the first post-reset sample gives result 0 and the second gives the correct delta.
